// File: rtl/lii_pkg.sv
// Shared LII definitions: class encoding, type-to-priority bitmap, index-width helper.
package lii_pkg;

  typedef enum logic {
    LII_CLS_LO = 1'b0,
    LII_CLS_HI = 1'b1
  } lii_cls_e;

  // Bit t set means packet type t travels in the hi class.
  localparam logic [15:0] LII_TYPE_PRIO = 16'h00F0;

  function automatic int lii_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic lii_cls_e lii_type_cls(input logic [3:0] pkt_type);
    return LII_TYPE_PRIO[pkt_type] ? LII_CLS_HI : LII_CLS_LO;
  endfunction

endpackage

// File: rtl/lii_rr_pick.sv
// Combinational rotate-priority picker: first set bit at or after ptr, wrapping to 0.
module lii_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      automatic int j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/lii_pkt_arbiter.sv
// Packet-atomic two-class round-robin arbiter for one LII output port, with lo-class aging.
module lii_pkt_arbiter
  import lii_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int AGE_LIMIT = 8,
  parameter  int AGE_W     = 4,
  localparam int IDX_W     = lii_idx_w(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     req_hi,
  input  logic [N-1:0]     req_last,
  input  logic             out_ready,
  output logic [N-1:0]     gnt,
  output logic             gnt_v,
  output logic             locked,
  output logic [IDX_W-1:0] owner,
  output logic             promo
);

  lii_cls_e         lock_cls;
  logic [IDX_W-1:0] ptr_hi, ptr_lo;
  logic [AGE_W-1:0] age;

  logic [N-1:0]     hi_set, lo_set, hi_oh, lo_oh, owner_oh;
  logic [IDX_W-1:0] hi_idx, lo_idx, win;
  logic             hi_any, lo_any, use_lo, accept, last_beat;
  lii_cls_e         cur_cls;
  logic [IDX_W-1:0] ptr_next;

  assign hi_set = req & req_hi;
  assign lo_set = req & ~req_hi;

  lii_rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick_hi (
    .req(hi_set), .ptr(ptr_hi), .onehot(hi_oh), .idx(hi_idx), .any(hi_any)
  );

  lii_rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick_lo (
    .req(lo_set), .ptr(ptr_lo), .onehot(lo_oh), .idx(lo_idx), .any(lo_any)
  );

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    promo  = !locked && (AGE_LIMIT != 0) && (age == AGE_W'(AGE_LIMIT)) && (|lo_set);
    use_lo = promo || !hi_any;
    if (locked) begin
      gnt     = owner_oh & req;
      gnt_v   = req[owner];
      win     = owner;
      cur_cls = lock_cls;
    end else begin
      gnt     = use_lo ? lo_oh  : hi_oh;
      gnt_v   = use_lo ? lo_any : hi_any;
      win     = use_lo ? lo_idx : hi_idx;
      cur_cls = use_lo ? LII_CLS_LO : LII_CLS_HI;
    end
    accept    = gnt_v && out_ready;
    last_beat = req_last[win];
    ptr_next  = (win == IDX_W'(N - 1)) ? '0 : win + IDX_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      locked   <= 1'b0;
      owner    <= '0;
      lock_cls <= LII_CLS_LO;
      ptr_hi   <= '0;
      ptr_lo   <= '0;
      age      <= '0;
    end else if (accept) begin
      if (!last_beat) begin
        locked   <= 1'b1;
        owner    <= win;
        lock_cls <= cur_cls;
      end else begin
        locked <= 1'b0;
        if (cur_cls == LII_CLS_HI) begin
          ptr_hi <= ptr_next;
          // Count hi completions only while a lo requester is actually waiting.
          if (|lo_set && age != AGE_W'(AGE_LIMIT)) age <= age + AGE_W'(1);
        end else begin
          ptr_lo <= ptr_next;
          age    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lii_pkt_arbiter.sv
// Directed self-checking bench for lii_pkt_arbiter (N=4, AGE_LIMIT=2).
module tb_lii_pkt_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req, req_hi, req_last;
  logic       out_ready;
  logic [3:0] gnt;
  logic       gnt_v, locked, promo;
  logic [1:0] owner;

  int n_checks = 0;
  int n_fail   = 0;

  lii_pkt_arbiter #(.N(4), .AGE_LIMIT(2), .AGE_W(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_hi(req_hi), .req_last(req_last),
    .out_ready(out_ready), .gnt(gnt), .gnt_v(gnt_v), .locked(locked),
    .owner(owner), .promo(promo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] h, input logic [3:0] l,
                       input logic rdy);
    req = r; req_hi = h; req_last = l; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = '0; req_hi = '0; req_last = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    do_reset();

    // Reset state, idle
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("rst_locked", locked, 0);
    check("rst_owner",  owner,  0);
    check("rst_gnt",    gnt,    0);
    check("rst_gnt_v",  gnt_v,  0);
    check("rst_promo",  promo,  0);
    adv();

    // T1: two lo single-beat requesters alternate 1,2,1,2
    drive(4'b0110, 4'b0000, 4'b1111, 1'b1); check("t1_g0", gnt, 4'b0010); check("t1_l0", locked, 0); adv();
    drive(4'b0110, 4'b0000, 4'b1111, 1'b1); check("t1_g1", gnt, 4'b0100); adv();
    drive(4'b0110, 4'b0000, 4'b1111, 1'b1); check("t1_g2", gnt, 4'b0010); adv();
    drive(4'b0110, 4'b0000, 4'b1111, 1'b1); check("t1_g3", gnt, 4'b0100); adv();

    // T2: 3-beat lo packet on in0, others join from beat 2
    do_reset();
    drive(4'b0001, 4'b0000, 4'b0000, 1'b1); check("t2_g0", gnt, 4'b0001); check("t2_l0", locked, 0); adv();
    drive(4'b1111, 4'b0000, 4'b1110, 1'b1); check("t2_g1", gnt, 4'b0001); check("t2_l1", locked, 1);
    check("t2_own", owner, 0); adv();
    drive(4'b1111, 4'b0000, 4'b1111, 1'b1); check("t2_g2", gnt, 4'b0001); check("t2_l2", locked, 1); adv();
    drive(4'b1111, 4'b0000, 4'b1111, 1'b1); check("t2_g3", gnt, 4'b0010); check("t2_l3", locked, 0); adv();

    // T3: owner in2 drops valid mid-packet for two cycles
    do_reset();
    drive(4'b0100, 4'b0000, 4'b0000, 1'b1); check("t3_g0", gnt, 4'b0100); adv();
    check("t3_own", owner, 2);
    for (int i = 0; i < 2; i++) begin
      drive(4'b1011, 4'b0000, 4'b1011, 1'b1);
      check("t3_bub_gnt", gnt, 0); check("t3_bub_v", gnt_v, 0); check("t3_bub_l", locked, 1);
      adv();
    end
    drive(4'b1111, 4'b0000, 4'b1011, 1'b1); check("t3_g1", gnt, 4'b0100); adv();
    drive(4'b1111, 4'b0000, 4'b1111, 1'b1); check("t3_g2", gnt, 4'b0100); adv();
    drive(4'b1011, 4'b0000, 4'b1111, 1'b1); check("t3_g3", gnt, 4'b1000); check("t3_l3", locked, 0); adv();

    // T4: aging promotes lo in3 after two hi packets from in0
    do_reset();
    drive(4'b1001, 4'b0001, 4'b1111, 1'b1); check("t4_g0", gnt, 4'b0001); check("t4_p0", promo, 0); adv();
    drive(4'b1001, 4'b0001, 4'b1111, 1'b1); check("t4_g1", gnt, 4'b0001); check("t4_p1", promo, 0); adv();
    drive(4'b1001, 4'b0001, 4'b1111, 1'b1); check("t4_g2", gnt, 4'b1000); check("t4_p2", promo, 1); adv();
    drive(4'b1001, 4'b0001, 4'b1111, 1'b1); check("t4_g3", gnt, 4'b0001); check("t4_p3", promo, 0); adv();
    drive(4'b1001, 4'b0001, 4'b1111, 1'b1); check("t4_g4", gnt, 4'b0001); check("t4_p4", promo, 0); adv();
    drive(4'b1001, 4'b0001, 4'b1111, 1'b1); check("t4_g5", gnt, 4'b1000); check("t4_p5", promo, 1); adv();

    // T5: backpressure holds the pick and the pointer
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1100, 4'b0000, 4'b1111, 1'b0);
      check("t5_hold_gnt", gnt, 4'b0100); check("t5_hold_v", gnt_v, 1);
      adv();
    end
    drive(4'b1100, 4'b0000, 4'b1111, 1'b1); check("t5_g0", gnt, 4'b0100); adv();
    drive(4'b1100, 4'b0000, 4'b1111, 1'b1); check("t5_g1", gnt, 4'b1000); adv();

    // T6: reset mid 4-beat packet clears lock and pointers asynchronously
    do_reset();
    drive(4'b0010, 4'b0000, 4'b1111, 1'b1); check("t6_g0", gnt, 4'b0010); adv();
    drive(4'b0100, 4'b0000, 4'b0000, 1'b1); check("t6_g1", gnt, 4'b0100); adv();
    drive(4'b0100, 4'b0000, 4'b0000, 1'b1); check("t6_g2", gnt, 4'b0100); adv();
    check("t6_pre_l", locked, 1); check("t6_pre_own", owner, 2);
    rstn = 1'b0;
    #1;
    check("t6_async_l", locked, 0); check("t6_async_own", owner, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    drive(4'b1111, 4'b0000, 4'b1111, 1'b1); check("t6_restart", gnt, 4'b0001); adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
